spike_encoder: RTL and testbench

SPIKE_ENCODER -- requirements
Module: spike_encoder

---
 rtl/spike_enc_pkg.sv | 23 ++
 rtl/spike_lfsr8.sv | 28 ++
 rtl/spike_encoder.sv | 132 +++++++++++++
 tb/tb_spike_encoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_enc_pkg.sv
// Shared definitions for the spike encoder.
// Holds the FSM state type, LFSR seed/tap constants, default parameter values
// and a saturating-increment helper.
package spike_enc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRefr
  } enc_state_e;

  // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3.
  localparam logic [7:0] LfsrSeed = 8'hB8;
  localparam logic [7:0] LfsrTaps = 8'b1011_1000;

  localparam int unsigned DefRefract = 2;
  localparam int unsigned DefWindow  = 256;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/spike_lfsr8.sv
// 8-bit Fibonacci LFSR used for stochastic spike encoding.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, loads the seed
//   step  - advance one state this cycle
//   value - current LFSR state
module spike_lfsr8
  import spike_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [7:0] value
);

  logic feedback;

  assign feedback = ^(value & LfsrTaps);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LfsrSeed;
    end else if (step) begin
      value <= {value[6:0], feedback};
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// Rate encoder: converts an 8-bit intensity into a spike train and reports the
// number of spikes per window of WINDOW active cycles.
// Default build uses a phase accumulator (carry = spike). Defining
// SPIKE_ENC_LFSR_EN selects stochastic encoding (spike when lfsr < intensity).
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   enable      - run request; low returns to idle and discards the window
//   intensity   - stimulus value, sampled on run entry and at window boundaries
//   spike       - registered one-cycle spike pulse
//   spike_count - spikes in last completed window (saturating at 255)
//   count_valid - one-cycle strobe when spike_count updates
module spike_encoder
  import spike_enc_pkg::*;
#(
  parameter int unsigned REFRACT = DefRefract,
  parameter int unsigned WINDOW  = DefWindow
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] intensity,
  output logic       spike,
  output logic [7:0] spike_count,
  output logic       count_valid
);

  localparam logic [7:0] WinLast    = 8'(WINDOW - 1);
  localparam bit         HasRefract = (REFRACT != 0);
  localparam logic [3:0] RefrLoad   = HasRefract ? 4'(REFRACT - 1) : 4'd0;

  enc_state_e state_q;
  logic [7:0] intensity_q;
  logic [7:0] acc_q;
  logic [7:0] win_cnt_q;
  logic [7:0] spk_cnt_q;
  logic [3:0] refr_cnt_q;

  logic       carry;
  logic       fire;
  logic [7:0] acc_run_d;
  logic [7:0] acc_refr_d;

`ifdef SPIKE_ENC_LFSR_EN
  logic [7:0] lfsr_value;
  logic       lfsr_step;

  assign lfsr_step = enable && (state_q != StIdle);

  spike_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  assign carry      = (lfsr_value < intensity_q);
  // Accumulator unused in stochastic mode; it stays at its idle value of 0.
  assign acc_run_d  = acc_q;
  assign acc_refr_d = acc_q;
`else
  logic [8:0] sum;

  assign sum        = {1'b0, acc_q} + {1'b0, intensity_q};
  assign carry      = sum[8];
  assign acc_run_d  = sum[7:0];
  // Clamp during refractory so the phase does not wrap and lose the overflow.
  assign acc_refr_d = sum[8] ? 8'hFF : sum[7:0];
`endif

  assign fire = (state_q == StRun) && carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      intensity_q <= 8'd0;
      acc_q       <= 8'd0;
      win_cnt_q   <= 8'd0;
      spk_cnt_q   <= 8'd0;
      refr_cnt_q  <= 4'd0;
      spike       <= 1'b0;
      spike_count <= 8'd0;
      count_valid <= 1'b0;
    end else if (!enable) begin
      state_q     <= StIdle;
      spike       <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      case (state_q)
        StRun, StRefr: begin
          if (state_q == StRun) begin
            acc_q <= acc_run_d;
            spike <= carry;
            if (carry && HasRefract) begin
              state_q    <= StRefr;
              refr_cnt_q <= RefrLoad;
            end
          end else begin
            acc_q <= acc_refr_d;
            spike <= 1'b0;
            if (refr_cnt_q == 4'd0) begin
              state_q <= StRun;
            end else begin
              refr_cnt_q <= refr_cnt_q - 4'd1;
            end
          end
          if (win_cnt_q == WinLast) begin
            win_cnt_q   <= 8'd0;
            spike_count <= sat_inc(spk_cnt_q, fire);
            count_valid <= 1'b1;
            spk_cnt_q   <= 8'd0;
            intensity_q <= intensity;
          end else begin
            win_cnt_q   <= win_cnt_q + 8'd1;
            spk_cnt_q   <= sat_inc(spk_cnt_q, fire);
            count_valid <= 1'b0;
          end
        end
        default: begin
          state_q     <= StRun;
          intensity_q <= intensity;
          acc_q       <= 8'd0;
          win_cnt_q   <= 8'd0;
          spk_cnt_q   <= 8'd0;
          spike       <= 1'b0;
          count_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: three instances with different REFRACT/WINDOW,
// compared every cycle against a behavioural rate-encoding model, plus literal
// expectations for the known-answer scenarios.
module tb_spike_encoder;

  localparam int NDut = 3;
  localparam int RefrP [NDut] = '{0, 3, 2};
  localparam int WinP  [NDut] = '{256, 256, 16};

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] intensity;
  logic       spike_w [NDut];
  logic [7:0] cnt_w   [NDut];
  logic       cv_w    [NDut];

  int vectors;
  int errors;

  // Model state
  bit m_act [NDut];
  int m_acc [NDut];
  int m_rr  [NDut];
  int m_wc  [NDut];
  int m_sc  [NDut];
  int m_iq  [NDut];
  bit e_spk [NDut];
  int e_cnt [NDut];
  bit e_cv  [NDut];

  int cv_seen [NDut];
  int cap     [NDut];
  int spike_hi0;

  spike_encoder #(.REFRACT(0), .WINDOW(256)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .intensity(intensity),
    .spike(spike_w[0]), .spike_count(cnt_w[0]), .count_valid(cv_w[0])
  );
  spike_encoder #(.REFRACT(3), .WINDOW(256)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .intensity(intensity),
    .spike(spike_w[1]), .spike_count(cnt_w[1]), .count_valid(cv_w[1])
  );
  spike_encoder #(.REFRACT(2), .WINDOW(16)) u_dutr (
    .clk(clk), .rst_n(rst_n), .enable(enable), .intensity(intensity),
    .spike(spike_w[2]), .spike_count(cnt_w[2]), .count_valid(cv_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NDut; i++) begin
      m_act[i] = 0; m_acc[i] = 0; m_rr[i] = 0; m_wc[i] = 0; m_sc[i] = 0;
      m_iq[i] = 0; e_spk[i] = 0; e_cnt[i] = 0; e_cv[i] = 0;
    end
  endtask

  // One clock of the rate encoder: phase accumulates intensity, overflow is a
  // spike; a spike opens RefrP cycles of silence; counts close every WinP cycles.
  task automatic model_step(input int i, input bit en, input int inten);
    int s;
    bit fire;
    if (!en) begin
      m_act[i] = 0; e_spk[i] = 0; e_cv[i] = 0;
    end else if (!m_act[i]) begin
      m_act[i] = 1; m_iq[i] = inten; m_acc[i] = 0; m_wc[i] = 0; m_sc[i] = 0;
      m_rr[i] = 0; e_spk[i] = 0; e_cv[i] = 0;
    end else begin
      s = m_acc[i] + m_iq[i];
      if (m_rr[i] == 0) begin
        fire = (s > 255);
        m_acc[i] = s % 256;
        if (fire && RefrP[i] > 0) m_rr[i] = RefrP[i];
      end else begin
        fire = 0;
        m_acc[i] = (s > 255) ? 255 : s;
        m_rr[i]--;
      end
      e_spk[i] = fire;
      if (m_wc[i] == WinP[i] - 1) begin
        e_cnt[i] = (m_sc[i] + fire > 255) ? 255 : m_sc[i] + fire;
        e_cv[i]  = 1;
        m_sc[i]  = 0;
        m_iq[i]  = inten;
        m_wc[i]  = 0;
      end else begin
        m_sc[i] = (m_sc[i] + fire > 255) ? 255 : m_sc[i] + fire;
        m_wc[i]++;
        e_cv[i] = 0;
      end
    end
  endtask

  always @(negedge rst_n) model_reset();

  // Per-cycle compare
  always @(posedge clk) begin
    bit en_s;
    int in_s;
    en_s = enable;
    in_s = intensity;
    if (rst_n) begin
      for (int i = 0; i < NDut; i++) model_step(i, en_s, in_s);
    end
    #1;
    for (int i = 0; i < NDut; i++) begin
      chk("spike", i, spike_w[i], e_spk[i]);
      chk("spike_count", i, cnt_w[i], e_cnt[i]);
      chk("count_valid", i, cv_w[i], e_cv[i]);
      if (cv_w[i]) begin
        cv_seen[i]++;
        cap[i] = cnt_w[i];
      end
    end
    if (spike_w[0]) spike_hi0++;
  end

  task automatic wait_cv(input int d, output int cyc);
    int start;
    start = cv_seen[d];
    cyc = 0;
    while (cv_seen[d] == start && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("cv_arrived", d, (cv_seen[d] != start) ? 1 : 0, 1);
  endtask

  task automatic restart(input int inten);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    intensity = 8'(inten);
  endtask

  initial begin
    int cyc;
    int snap;
    vectors = 0;
    errors = 0;
    spike_hi0 = 0;
    for (int i = 0; i < NDut; i++) begin
      cv_seen[i] = 0;
      cap[i] = 0;
    end
    model_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    intensity = 8'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDut; i++) begin
      chk("rst_spike", i, spike_w[i], 0);
      chk("rst_count", i, cnt_w[i], 0);
      chk("rst_valid", i, cv_w[i], 0);
    end
    rst_n = 1'b1;

    // 128: spike every other cycle, 128 per window
    @(negedge clk);
    intensity = 8'd128;
    enable = 1'b1;
    wait_cv(0, cyc);
    chk("win128", 0, cap[0], 128);

    // Mid-window change takes effect only from the next window
    repeat (50) @(negedge clk);
    intensity = 8'd255;
    wait_cv(0, cyc);
    chk("mid_change_cur", 0, cap[0], 128);
    wait_cv(0, cyc);
    chk("mid_change_next", 0, cap[0], 255);

    // Zero intensity never spikes
    restart(0);
    spike_hi0 = 0;
    wait_cv(0, cyc);
    chk("win0", 0, cap[0], 0);
    chk("spike_hi0", 0, spike_hi0, 0);

    // Full-scale, with and without refractory
    restart(255);
    wait_cv(0, cyc);
    chk("win_latency", 0, cyc, 257);
    chk("win255", 0, cap[0], 255);
    chk("win255_refr3", 1, cap[1], 64);

    // Partial window discarded on enable drop
    restart(77);
    repeat (101) @(negedge clk);
    enable = 1'b0;
    snap = cv_seen[0];
    repeat (6) @(negedge clk);
    chk("no_valid_on_drop", 0, cv_seen[0] - snap, 0);
    chk("count_held", 0, cnt_w[0], 255);
    enable = 1'b1;
    wait_cv(0, cyc);
    chk("rewin_latency", 0, cyc, 257);
    chk("win77", 0, cap[0], 77);

    // Asynchronous reset mid-window
    repeat (40) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDut; i++) begin
      chk("arst_spike", i, spike_w[i], 0);
      chk("arst_count", i, cnt_w[i], 0);
      chk("arst_valid", i, cv_w[i], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Randomised run
    repeat (4000) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) intensity = 8'($urandom_range(0, 255));
      if (enable) begin
        if ($urandom_range(0, 299) == 0) enable = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        enable = 1'b1;
      end
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
